// File: rtl/mem_responder_if.sv
// Request/response bus between the multicycle core's control FSM and mem_responder.
// master = core side, slave = memory side.
interface mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed RAM that services one fetch/load/store at a time with a fixed latency.
// Loads are read on the edge entering RESPOND; stores commit on the edge leaving it.
module mem_responder #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic           clk,
  input  logic           reset,
  mem_responder_if.slave bus,
  output logic           busy
);
  localparam int unsigned IdxW    = $clog2(DEPTH);
  localparam logic [3:0]  CntInit = 4'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StWait, StRespond} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              write_q, write_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [31:0]       mem [DEPTH];

  logic [31:0]       cur_addr;
  logic              cur_write;
  logic              cur_err;
  logic [IdxW-1:0]   cur_idx;
  logic [IdxW-1:0]   wr_idx;
  logic              enter_rsp;

  // With LATENCY==1 RESPOND is entered on the accept edge, before addr_q holds the request.
  assign cur_addr  = (state_q == StIdle) ? bus.req_addr  : addr_q;
  assign cur_write = (state_q == StIdle) ? bus.req_write : write_q;
  assign cur_idx   = cur_addr[2 +: IdxW];
  assign cur_err   = (cur_addr[1:0] != 2'b00) || ({2'b00, cur_addr[31:2]} >= 32'(DEPTH));
  assign wr_idx    = addr_q[2 +: IdxW];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    write_d   = write_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    enter_rsp = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          write_d = bus.req_write;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          if (LATENCY == 1) begin
            state_d   = StRespond;
            enter_rsp = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = CntInit;
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d   = StRespond;
          enter_rsp = 1'b1;
        end
      end
      StRespond: state_d = StIdle;
      default:   state_d = StIdle;
    endcase

    if (enter_rsp) begin
      err_d = cur_err;
      if (!cur_write) begin
        rdata_d = cur_err ? 32'h0 : mem[cur_idx];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      write_q <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Array is deliberately not reset; reset forces IDLE first, so a pending store is dropped.
  always_ff @(posedge clk) begin
    if (state_q == StRespond && write_q && !err_q) begin
      mem[wr_idx] <= wdata_q;
    end
  end

  assign bus.req_ready = (state_q == StIdle);
  assign bus.rsp_valid = (state_q == StRespond);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign busy          = (state_q != StIdle);
endmodule
